// File: rtl/ram_access_pkg.sv
// +----------------------------------------------------------------------+
// | ram_access_pkg: shared funct3 codes, FSM states, address helpers      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ram_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int BYTE_ADDR_WIDTH(input int ram_a_width);
    return ram_a_width + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_lane_aligner.sv
// +----------------------------------------------------------------------+
// | ram_lane_aligner: store byte-lane merge, load extract/extend, checks  |
// | Optional: RAM_ACCESS_MISALIGN_CHECK_EN flags misaligned H/W accesses  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ram_lane_aligner
  import ram_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic        i_write,
  output logic [31:0] o_merged,
  output logic [31:0] o_load,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bad_code;
  logic        w_misalign;

  always_comb begin
    w_byte = i_word[8*i_offset +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    o_load = '0;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_W:    o_load = i_word;
      F3_BU:   o_load = {24'd0, w_byte};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = '0;
    endcase

    o_merged = i_word;
    case (i_funct3)
      F3_B: o_merged[8*i_offset +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
        else             o_merged[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_merged = i_wdata;
      default: o_merged = i_word;
    endcase

    if (i_write) w_bad_code = !(i_funct3 inside {F3_B, F3_H, F3_W});
    else         w_bad_code = !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef RAM_ACCESS_MISALIGN_CHECK_EN
    w_misalign = ((i_funct3[1:0] == 2'b01) && i_offset[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_offset != 2'b00));
`else
    w_misalign = 1'b0;
`endif

    o_illegal = w_bad_code || w_misalign;
  end

endmodule

`default_nettype wire

// File: rtl/ram_access_controller.sv
// +----------------------------------------------------------------------+
// | ram_access_controller: RV32 byte-addressed load/store to word RAM     |
// | Optional: RAM_ACCESS_MISALIGN_CHECK_EN (see ram_lane_aligner)         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ram_access_controller
  import ram_access_pkg::*;
#(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_req_valid,
  output logic                                   o_req_ready,
  input  logic                                   i_req_write,
  input  logic [2:0]                             i_req_funct3,
  input  logic [BYTE_ADDR_WIDTH(RAM_A_WIDTH)-1:0] i_req_address,
  input  logic [31:0]                            i_req_wdata,
  output logic                                   o_resp_valid,
  input  logic                                   i_resp_ready,
  output logic [31:0]                            o_resp_rdata,
  output logic                                   o_resp_error,
  output logic [RAM_A_WIDTH-1:0]                 o_ram_read_address,
  input  logic [31:0]                            i_ram_data_out,
  output logic [RAM_A_WIDTH-1:0]                 o_ram_write_address,
  output logic [31:0]                            o_ram_data_in,
  output logic                                   o_ram_write_enable
);

  localparam int C_BYTE_AW = BYTE_ADDR_WIDTH(RAM_A_WIDTH);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_write;
  logic [2:0]             r_funct3;
  logic [C_BYTE_AW-1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;
  logic                   r_error;

  logic                   w_accept;
  logic [31:0]            w_merged;
  logic [31:0]            w_load;
  logic                   w_illegal;

  assign w_accept = i_req_valid && (r_state == IDLE);

  ram_lane_aligner u_aligner (
    .i_word    (i_ram_data_out),
    .i_wdata   (r_wdata),
    .i_funct3  (r_funct3),
    .i_offset  (r_addr[1:0]),
    .i_write   (r_write),
    .o_merged  (w_merged),
    .o_load    (w_load),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = READ;
      READ:    w_next_state = RESP;
      RESP:    if (i_resp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Write enable decodes straight from the state so an async reset drops it at once.
  always_comb begin
    o_req_ready        = 1'b0;
    o_resp_valid       = 1'b0;
    o_ram_write_enable = 1'b0;
    o_ram_read_address = r_addr[C_BYTE_AW-1:2];
    case (r_state)
      IDLE: begin
        o_req_ready        = 1'b1;
        o_ram_read_address = i_req_address[C_BYTE_AW-1:2];
      end
      READ:    o_ram_write_enable = r_write && !w_illegal;
      RESP:    o_resp_valid = 1'b1;
      default: o_req_ready = 1'b0;
    endcase
  end

  assign o_ram_write_address = r_addr[C_BYTE_AW-1:2];
  assign o_ram_data_in       = o_ram_write_enable ? w_merged : 32'd0;
  assign o_resp_rdata        = r_rdata;
  assign o_resp_error        = r_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= i_req_write;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_address;
        r_wdata  <= i_req_wdata;
      end
      if (r_state == READ) begin
        r_rdata <= (r_write || w_illegal) ? 32'd0 : w_load;
        r_error <= w_illegal;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_access_controller.sv
// +----------------------------------------------------------------------+
// | tb_ram_access_controller: vector table, corner sequences, random run  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ram_access_controller;

  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [2:0]  i_req_funct3 = '0;
  logic [13:0] i_req_address = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b1;
  logic [31:0] o_resp_rdata;
  logic        o_resp_error;
  logic [AW-1:0] o_ram_read_address;
  logic [31:0] ram_dout;
  logic [AW-1:0] o_ram_write_address;
  logic [31:0] o_ram_data_in;
  logic        o_ram_write_enable;

  always #5 clk = ~clk;

  ram_access_controller #(.RAM_A_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_req_valid         (i_req_valid),
    .o_req_ready         (o_req_ready),
    .i_req_write         (i_req_write),
    .i_req_funct3        (i_req_funct3),
    .i_req_address       (i_req_address),
    .i_req_wdata         (i_req_wdata),
    .o_resp_valid        (o_resp_valid),
    .i_resp_ready        (i_resp_ready),
    .o_resp_rdata        (o_resp_rdata),
    .o_resp_error        (o_resp_error),
    .o_ram_read_address  (o_ram_read_address),
    .i_ram_data_out      (ram_dout),
    .o_ram_write_address (o_ram_write_address),
    .o_ram_data_in       (o_ram_data_in),
    .o_ram_write_enable  (o_ram_write_enable)
  );

  // Synchronous-read RAM with a backdoor preload path.
  logic [31:0]   ram [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  int            we_count = 0;

  always @(posedge clk) begin
    ram_dout <= ram[o_ram_read_address];
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (o_ram_write_enable) begin
      ram[o_ram_write_address] <= o_ram_data_in;
      we_count++;
    end
  end

  logic [31:0] model_mem [0:15];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference: rules applied with byte arithmetic on a word array.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [13:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int bytes, base, idx;
    logic [31:0] cur;
    longint mask, val;
    er = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    bytes = 1 << f3[1:0];
`ifdef RAM_ACCESS_MISALIGN_CHECK_EN
    if (!er && (int'(a) % bytes) != 0) er = 1'b1;
`endif
    rd = 32'd0;
    if (er) return;
    idx  = int'(a) / 4;
    base = ((int'(a) % 4) / bytes) * bytes;
    cur  = model_mem[idx];
    if (w) begin
      for (int b = 0; b < bytes; b++)
        cur[8*(base+b) +: 8] = wd[8*b +: 8];
      model_mem[idx] = cur;
    end else begin
      mask = (64'd1 << (8*bytes)) - 1;
      val  = (longint'(cur) >> (8*base)) & mask;
      if (!f3[2] && bytes < 4 && val[8*bytes-1]) val = val | ~mask;
      rd = val[31:0];
    end
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = AW'(idx); pre_data = v;
    model_mem[idx] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [13:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int guard;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = w; i_req_funct3 = f3;
    i_req_address = a; i_req_wdata = wd; i_resp_ready = 1'b1;
    guard = 0;
    while (!o_req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_resp_valid) begin lat = c; break; end
    end
    rd = o_resp_rdata; er = o_resp_error;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [13:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] rd, erd, hold;
    logic er, eer, timed_out;
    int lat, wc0;

    tbl[0]  = '{1'b0, 3'd0, 14'h3, 32'h0,        32'h00000011, 1'b0};
    tbl[1]  = '{1'b0, 3'd4, 14'h0, 32'h0,        32'h00000044, 1'b0};
    tbl[2]  = '{1'b0, 3'd1, 14'h4, 32'h0,        32'hFFFFF0FF, 1'b0};
    tbl[3]  = '{1'b0, 3'd5, 14'h6, 32'h0,        32'h00008000, 1'b0};
    tbl[4]  = '{1'b1, 3'd0, 14'h9, 32'h12345677, 32'h00000000, 1'b0};
    tbl[5]  = '{1'b0, 3'd2, 14'h8, 32'h0,        32'hAABB77DD, 1'b0};
    tbl[6]  = '{1'b1, 3'd4, 14'h0, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b0, 3'd2, 14'h0, 32'h0,        32'h11223344, 1'b0};
`ifdef RAM_ACCESS_MISALIGN_CHECK_EN
    tbl[8]  = '{1'b0, 3'd2, 14'h2, 32'h0,        32'h00000000, 1'b1};
`else
    tbl[8]  = '{1'b0, 3'd2, 14'h2, 32'h0,        32'h11223344, 1'b0};
`endif
    tbl[9]  = '{1'b0, 3'd3, 14'h0, 32'h0,        32'h00000000, 1'b1};
    tbl[10] = '{1'b1, 3'd1, 14'h6, 32'h0000ABCD, 32'h00000000, 1'b0};
    tbl[11] = '{1'b0, 3'd2, 14'h4, 32'h0,        32'hABCDF0FF, 1'b0};
    tbl[12] = '{1'b1, 3'd2, 14'hC, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 14'hF, 32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[14] = '{1'b0, 3'd4, 14'hE, 32'h0,        32'h000000AD, 1'b0};

    // Preload while held in reset.
    preload(0, 32'h11223344);
    preload(1, 32'h8000F0FF);
    preload(2, 32'hAABBCCDD);
    for (int k = 3; k < 16; k++)
      preload(k, (k == 5) ? 32'h55555555 : 32'(k) * 32'h9E3779B9);

    @(negedge clk);
    check("reset_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("reset_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check("reset_resp_rdata", o_resp_rdata, 32'd0);
    check("reset_resp_error", {31'd0, o_resp_error}, 32'd0);
    check("reset_ram_we", {31'd0, o_ram_write_enable}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      wc0 = we_count;
      do_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er, lat);
      model(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, erd, eer);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_error", i), {31'd0, er}, {31'd0, tbl[i].exp_er});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      if (tbl[i].w && tbl[i].exp_er)
        check($sformatf("vec%0d_no_write", i), 32'(we_count - wc0), 32'd0);
      if (i == 4) check("sb_ram_word2", ram[2], 32'hAABB77DD);
    end
    check("err_store_word0_kept", ram[0], 32'h11223344);

    // Response back-pressure: output held while consumer stalls.
    model(1'b0, 3'd2, 14'h4, 32'h0, erd, eer);
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_funct3 = 3'd2;
    i_req_address = 14'h4; i_resp_ready = 1'b0;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_resp_valid) begin timed_out = 1'b0; break; end
    end
    check("stall_resp_seen", {31'd0, timed_out}, 32'd0);
    hold = o_resp_rdata;
    check("stall_rdata", hold, erd);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid_held", {31'd0, o_resp_valid}, 32'd1);
      check("stall_rdata_held", o_resp_rdata, hold);
      check("stall_req_ready_low", {31'd0, o_req_ready}, 32'd0);
    end
    i_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_released_ready", {31'd0, o_req_ready}, 32'd1);
    check("stall_released_valid", {31'd0, o_resp_valid}, 32'd0);

    // Reset in the middle of a store's READ cycle.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_funct3 = 3'd2;
    i_req_address = 14'h14; i_req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_we_before", {31'd0, o_ram_write_enable}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_we_killed", {31'd0, o_ram_write_enable}, 32'd0);
    check("rst_mid_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_mid_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check("rst_mid_rdata", o_resp_rdata, 32'd0);
    check("rst_mid_error", {31'd0, o_resp_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_word5_kept", ram[5], 32'h55555555);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      logic w;
      logic [2:0] f3;
      logic [13:0] a;
      logic [31:0] wd;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 14'($urandom_range(0, 63));
      wd = $urandom;
      do_req(w, f3, a, wd, rd, er, lat);
      model(w, f3, a, wd, erd, eer);
      check($sformatf("rnd%0d_rdata", n), rd, erd);
      check($sformatf("rnd%0d_error", n), {31'd0, er}, {31'd0, eer});
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd2);
    end
    for (int k = 0; k < 16; k++)
      check($sformatf("final_word%0d", k), ram[k], model_mem[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
